// File: rtl/alu_retire_stage.sv
// alu_retire_stage: retire stage directly behind the 8-bit ALU.
// Captures the ALU result, its Zero/Sign outputs and the destination tag into a
// 2-entry skid buffer. The head entry is presented to register-file writeback
// over valid/ready. Also holds the architectural Zero/Sign flags, which update
// at retirement, and a wrapping retired-op counter.
// Optional macro ALU_RETIRE_FWD_EN adds fwd_valid/fwd_dst/fwd_data, which expose
// the youngest buffered entry for operand bypass.
module alu_retire_stage #(
  parameter int W   = 8,
  parameter int Ops = 3,
  parameter int RA  = 3,
  parameter int CW  = 16
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_zero,
  input  logic           in_sign,
  input  logic [Ops-1:0] in_op,
  input  logic           in_wr_en,
  input  logic [RA-1:0]  in_dst,
  output logic           wb_valid,
  input  logic           wb_ready,
  output logic [W-1:0]   wb_data,
  output logic [RA-1:0]  wb_dst,
  output logic           wb_wr_en,
  output logic           flag_zero,
  output logic           flag_sign,
  output logic [CW-1:0]  ret_cnt
`ifdef ALU_RETIRE_FWD_EN
  ,
  output logic           fwd_valid,
  output logic [RA-1:0]  fwd_dst,
  output logic [W-1:0]   fwd_data
`endif
);

  typedef struct packed {
    logic [W-1:0]  data;
    logic          zero;
    logic          sign;
    logic          upd;
    logic          wr_en;
    logic [RA-1:0] dst;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

  state_t state;
  entry_t h, s, nxt;
  logic   in_fire, wb_fire;

  // Handshakes come from registered state only, so wb_ready never reaches in_ready.
  assign in_ready = (state != FULL);
  assign wb_valid = (state != EMPTY);
  assign in_fire  = in_valid & in_ready;
  assign wb_fire  = wb_valid & wb_ready;

  // Pack the incoming ALU result. Only the defined ALU opcodes (0..3) may touch the flags.
  always_comb begin
    nxt       = '0;
    nxt.data  = in_data;
    nxt.zero  = in_zero;
    nxt.sign  = in_sign;
    nxt.upd   = (in_op <= Ops'(3));
    nxt.wr_en = in_wr_en;
    nxt.dst   = in_dst;
  end

  assign wb_data  = h.data;
  assign wb_dst   = h.dst;
  assign wb_wr_en = h.wr_en;

  // Skid-buffer FSM, flag update at retirement, and retired-op counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= EMPTY;
      h         <= '0;
      s         <= '0;
      flag_zero <= 1'b0;
      flag_sign <= 1'b0;
      ret_cnt   <= '0;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          h     <= nxt;
          state <= HALF;
        end
        HALF: begin
          if (in_fire && wb_fire) h <= nxt;
          else if (in_fire) begin
            s     <= nxt;
            state <= FULL;
          end else if (wb_fire) state <= EMPTY;
        end
        FULL: if (wb_fire) begin
          h     <= s;
          state <= HALF;
        end
        default: state <= EMPTY;
      endcase
      if (wb_fire) begin
        ret_cnt <= ret_cnt + 1'b1;
        if (h.upd) begin
          flag_zero <= h.zero;
          flag_sign <= h.sign;
        end
      end
    end
  end

`ifdef ALU_RETIRE_FWD_EN
  entry_t young;
  // The youngest entry sits in the skid register when FULL, otherwise in the head.
  always_comb begin
    young     = (state == FULL) ? s : h;
    fwd_valid = (state != EMPTY) && young.wr_en;
    fwd_dst   = young.dst;
    fwd_data  = young.data;
  end
`endif

endmodule

// File: tb/tb_alu_retire_stage.sv
// Directed bench for alu_retire_stage. A second instance with CW=4 shares the
// stimulus so the counter wrap can be observed.
module tb_alu_retire_stage;
  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       in_valid, in_zero, in_sign, in_wr_en, wb_ready;
  logic [7:0] in_data;
  logic [2:0] in_op, in_dst;

  logic        in_ready, wb_valid, wb_wr_en, flag_zero, flag_sign;
  logic [7:0]  wb_data;
  logic [2:0]  wb_dst;
  logic [15:0] ret_cnt;

  logic        in_ready4, wb_valid4, wb_wr_en4, flag_zero4, flag_sign4;
  logic [7:0]  wb_data4;
  logic [2:0]  wb_dst4;
  logic [3:0]  ret_cnt4;
`ifdef ALU_RETIRE_FWD_EN
  logic       fwd_valid, fwd_valid4;
  logic [2:0] fwd_dst, fwd_dst4;
  logic [7:0] fwd_data, fwd_data4;
`endif

  int total = 0;
  int bad   = 0;

  alu_retire_stage #(.W(8), .Ops(3), .RA(3), .CW(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_zero(in_zero), .in_sign(in_sign), .in_op(in_op),
    .in_wr_en(in_wr_en), .in_dst(in_dst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_dst(wb_dst), .wb_wr_en(wb_wr_en),
    .flag_zero(flag_zero), .flag_sign(flag_sign), .ret_cnt(ret_cnt)
`ifdef ALU_RETIRE_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data)
`endif
  );

  alu_retire_stage #(.W(8), .Ops(3), .RA(3), .CW(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_zero(in_zero), .in_sign(in_sign), .in_op(in_op),
    .in_wr_en(in_wr_en), .in_dst(in_dst), .wb_valid(wb_valid4), .wb_ready(wb_ready),
    .wb_data(wb_data4), .wb_dst(wb_dst4), .wb_wr_en(wb_wr_en4),
    .flag_zero(flag_zero4), .flag_sign(flag_sign4), .ret_cnt(ret_cnt4)
`ifdef ALU_RETIRE_FWD_EN
    , .fwd_valid(fwd_valid4), .fwd_dst(fwd_dst4), .fwd_data(fwd_data4)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs set at a falling edge are captured at the rising edge,
  // then outputs are checked at the next falling edge.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] op,
                       input logic z, input logic sg, input logic we, input logic [2:0] dst);
    in_valid = v; in_data = d; in_op = op; in_zero = z; in_sign = sg;
    in_wr_en = we; in_dst = dst;
  endtask

  initial begin
    Reset_n = 1'b0; wb_ready = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    step(); step();
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wb_data",  32'(wb_data),  32'h0);
    chk("rst_flags",    32'({flag_zero, flag_sign}), 32'd0);
    chk("rst_cnt",      32'(ret_cnt),  32'd0);
    Reset_n = 1'b1;
    step();

    // Single entry, then retirement updates flags and counter.
    wb_ready = 1'b1;
    drive(1'b1, 8'h05, 3'd0, 1'b0, 1'b1, 1'b1, 3'd2);
    step();
    in_valid = 1'b0;
    chk("t1_wb_valid", 32'(wb_valid), 32'd1);
    chk("t1_wb_data",  32'(wb_data),  32'h05);
    chk("t1_wb_dst",   32'(wb_dst),   32'd2);
    chk("t1_no_flag_at_capture", 32'(flag_sign), 32'd0);
    step();
    chk("t1_flag_sign", 32'(flag_sign), 32'd1);
    chk("t1_flag_zero", 32'(flag_zero), 32'd0);
    chk("t1_cnt",       32'(ret_cnt),   32'd1);
    chk("t1_empty",     32'(wb_valid),  32'd0);

    // Backpressure: two entries fill the buffer, third waits upstream.
    wb_ready = 1'b0;
    drive(1'b1, 8'h11, 3'd1, 1'b0, 1'b0, 1'b1, 3'd1);
    step();
    chk("t2_ready_half", 32'(in_ready), 32'd1);
    drive(1'b1, 8'h22, 3'd1, 1'b0, 1'b0, 1'b1, 3'd2);
    step();
    chk("t2_ready_full", 32'(in_ready), 32'd0);
    chk("t2_head_11",    32'(wb_data),  32'h11);
    drive(1'b1, 8'h33, 3'd1, 1'b0, 1'b0, 1'b1, 3'd3);
    step();
    chk("t2_head_stable", 32'(wb_data),  32'h11);
    chk("t2_still_full",  32'(in_ready), 32'd0);
    wb_ready = 1'b1;
    step();
    chk("t2_head_22",    32'(wb_data),  32'h22);
    chk("t2_cnt_after1", 32'(ret_cnt),  32'd2);
    step();
    in_valid = 1'b0;
    chk("t2_head_33",    32'(wb_data),  32'h33);
    chk("t2_dst_33",     32'(wb_dst),   32'd3);
    step();
    chk("t2_drained",    32'(wb_valid), 32'd0);
    chk("t2_cnt",        32'(ret_cnt),  32'd4);

    // Streaming: one accept and one retire per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h40 + i), 3'd0, 1'b0, 1'b0, 1'b1, 3'(i));
      step();
      chk("t3_stream_data",  32'(wb_data),  32'(8'h40 + i));
      chk("t3_stream_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("t3_cnt", 32'(ret_cnt), 32'd14);

    // Undefined opcode (101) does not touch flags; wr_en=0 still retires.
    drive(1'b1, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4);
    step();
    chk("t4_capture_no_flag", 32'(flag_zero), 32'd0);
    drive(1'b1, 8'h80, 3'b101, 1'b0, 1'b1, 1'b0, 3'd5);
    step();
    in_valid = 1'b0;
    chk("t4_wr_en0", 32'(wb_wr_en), 32'd0);
    chk("t4_first_zero", 32'(flag_zero), 32'd1);
    step();
    chk("t4_flag_zero", 32'(flag_zero), 32'd1);
    chk("t4_flag_sign", 32'(flag_sign), 32'd0);
    chk("t4_cnt",       32'(ret_cnt),   32'd16);

    // Asynchronous reset while FULL.
    wb_ready = 1'b0;
    drive(1'b1, 8'h55, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1);
    step();
    drive(1'b1, 8'h66, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2);
    step();
    in_valid = 1'b0;
    chk("t5_full", 32'(in_ready), 32'd0);
    #2 Reset_n = 1'b0;
    #1;
    chk("t5_rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t5_rst_flags",    32'({flag_zero, flag_sign}), 32'd0);
    chk("t5_rst_cnt",      32'(ret_cnt),  32'd0);
    chk("t5_rst_data",     32'(wb_data),  32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    wb_ready = 1'b1;
    drive(1'b1, 8'h77, 3'd2, 1'b1, 1'b0, 1'b1, 3'd7);
    step();
    in_valid = 1'b0;
    chk("t5_post_data", 32'(wb_data), 32'h77);
    step();
    chk("t5_post_cnt",  32'(ret_cnt),  32'd1);
    chk("t5_post_zero", 32'(flag_zero), 32'd1);

    // Counter wrap on the CW=4 instance: 17 retirements -> 1.
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(i), 3'd0, 1'b0, 1'b0, 1'b1, 3'd0);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("t6_cnt16",    32'(ret_cnt),  32'd17);
    chk("t6_cnt4_wrap", 32'(ret_cnt4), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
